mon_exp_loader: RTL and testbench

//  Host-side initiator for mon_exp: accepts operand words over a valid/ready stream, writes them into
//  the operand BRAM through its second write port, pulses start, waits for mon_exp's stop edge, captures
//  ans, and streams the result back out in DBITS-wide chunks. Sits between host I/F and the mon_exp/bram pair.

---
 rtl/mon_exp_loader.sv | 131 +++++++++++++
 tb/tb_mon_exp_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mon_exp_loader.sv
// Host-side initiator for mon_exp: streams operands into the BRAM, pulses start, captures ans on stop's
// rising edge and returns it in DBITS-wide chunks. Optional WAIT watchdog: MON_EXP_LOADER_TIMEOUT_EN.
module mon_exp_loader #(
    parameter int bitLen         = 1024,
    parameter int ABITS          = 8,
    parameter int DBITS          = 512,
    parameter int NWORDS         = 4,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DBITS-1:0]  in_data,
    output logic [ABITS-1:0]  wr_addr2,
    output logic [DBITS-1:0]  wr_data2,
    output logic              wr_en2,
    output logic              start,
    input  logic              stop,
    input  logic [bitLen:0]   ans,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DBITS-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int OUT_WORDS = (bitLen + DBITS) / DBITS;
    localparam int CW        = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int NW        = $clog2(NWORDS + 1);

    if (longint'(BASE_ADDR) + NWORDS - 1 >= (64'sd1 <<< ABITS)) begin : g_addr_chk
        $error("mon_exp_loader: operand words do not fit in the BRAM address space");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("mon_exp_loader: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;
    state_t state, state_n;

    logic [NW-1:0]                  cnt;
    logic [CW-1:0]                  chunk;
    logic [bitLen:0]                ans_q;
    logic                           stop_q;
    logic                           xfer, evt, last, tmo_hit;
    logic [OUT_WORDS-1:0][DBITS-1:0] ans_w;

    assign evt      = stop & ~stop_q;
    assign last     = (chunk == CW'(OUT_WORDS - 1));
    // Gated by rst so the port reads 0 while reset is held, even though the state is IDLE.
    assign in_ready = ~rst & ((state == IDLE) | ((state == LOAD) & (cnt != NW'(NWORDS))));
    assign xfer     = in_valid & in_ready;
    assign start    = (state == START);
    assign busy     = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) & last;
    assign ans_w     = (OUT_WORDS*DBITS)'(ans_q);
    assign out_data  = (state == DRAIN) ? ans_w[chunk] : '0;

`ifdef MON_EXP_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;
    logic          err_q;

    assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == WAIT) & ~evt & tmo_hit;
            tmo   <= (state == WAIT) ? tmo + 1'b1 : '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (xfer) state_n = LOAD;
            // Linger in LOAD one cycle after the final word so start follows the last write.
            LOAD:  if (cnt == NW'(NWORDS)) state_n = START;
            START: state_n = WAIT;
            WAIT: begin
                if (evt)          state_n = DRAIN;
                else if (tmo_hit) state_n = IDLE;
            end
            DRAIN: if (out_ready && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            chunk    <= '0;
            ans_q    <= '0;
            stop_q   <= 1'b0;
            wr_en2   <= 1'b0;
            wr_addr2 <= '0;
            wr_data2 <= '0;
        end else begin
            stop_q <= stop;
            wr_en2 <= xfer;
            if (xfer) begin
                wr_addr2 <= ABITS'(BASE_ADDR) + ABITS'(cnt);
                wr_data2 <= in_data;
                cnt      <= cnt + 1'b1;
            end
            if (state == START) cnt <= '0;
            if (state == WAIT && evt) begin
                ans_q <= ans;
                chunk <= '0;
            end
            if (state == DRAIN && out_ready) chunk <= chunk + 1'b1;
        end
    end
endmodule

// File: tb/tb_mon_exp_loader.sv
// Directed bench for mon_exp_loader: job table plus reset, held-stop and timeout sequences.
module tb_mon_exp_loader;
    localparam int BL = 1024, AB = 8, DB = 512, NWD = 4;
`ifdef MON_EXP_LOADER_TIMEOUT_EN
    localparam int DLY = 10;
`else
    localparam int DLY = 20;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [DB-1:0] in_data = '0;
    logic [AB-1:0] wr_addr2;
    logic [DB-1:0] wr_data2;
    logic wr_en2, start, stop = 1'b0;
    logic [BL:0] ans = '0;
    logic out_valid, out_ready = 1'b0, out_last, busy, err;
    logic [DB-1:0] out_data;

    int n_chk = 0, n_fail = 0, n_out = 0;

    mon_exp_loader #(.bitLen(BL), .ABITS(AB), .DBITS(DB), .NWORDS(NWD), .BASE_ADDR(0),
                     .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_addr2(wr_addr2), .wr_data2(wr_data2), .wr_en2(wr_en2), .start(start), .stop(stop),
        .ans(ans), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) if (out_valid && out_ready) n_out++;

    typedef struct {
        logic [DB-1:0] w [NWD];
        logic [BL:0]   a;
        logic [DB-1:0] e [3];
        logic [2:0]    stall;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(); @(posedge clk); #1; endtask

    // Sends NWD words without gaps; returns in the first WAIT cycle.
    task automatic load_and_start(input logic [DB-1:0] w [NWD]);
        for (int i = 0; i < NWD; i++) begin
            in_valid = 1'b1; in_data = w[i];
            chk("in_ready", in_ready, 1);
            step();
            chk("wr_en2", wr_en2, 1);
            chk("wr_addr2", wr_addr2, i);
            chk("wr_data2", wr_data2, w[i]);
            chk("busy_load", busy, 1);
            chk("start_early", start, 0);
        end
        in_valid = 1'b0;
        chk("in_ready_full", in_ready, 0);
        step();
        chk("start_pulse", start, 1);
        chk("wr_en2_off", wr_en2, 0);
        chk("busy_start", busy, 1);
        step();
        chk("start_end", start, 0);
    endtask

    task automatic finish_job(input int dly, input logic [BL:0] a,
                              input logic [DB-1:0] e [3], input logic [2:0] stall);
        int t;
        for (int i = 0; i < dly; i++) step();
        chk("no_out_in_wait", out_valid, 0);
        n_out = 0;
        stop = 1'b1; ans = a;
        t = 0;
        while (!out_valid && t < 50) begin step(); t++; end
        chk("out_valid_arrive", out_valid, 1);
        ans = '0;
        for (int j = 0; j < 3; j++) begin
            chk("out_data", out_data, e[j]);
            chk("out_last", out_last, (j == 2));
            if (stall[j]) begin
                out_ready = 1'b0;
                step();
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, e[j]);
                chk("stall_last", out_last, (j == 2));
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("out_valid_done", out_valid, 0);
        chk("busy_done", busy, 0);
        chk("n_transfers", n_out, 3);
        stop = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en2"}, wr_en2, 0);
        chk({tag, "_wr_addr2"}, wr_addr2, 0);
        chk({tag, "_wr_data2"}, wr_data2, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [DB-1:0] w [NWD];
        vecs[0].w = '{512'd435, 512'd0, 512'd571, 512'd0};
        vecs[0].a = 1025'd311;
        vecs[0].e = '{512'd311, 512'd0, 512'd0};
        vecs[0].stall = 3'b000;
        vecs[1].w = '{512'd1, 512'd2, 512'd3, 512'd4};
        vecs[1].a = {1025{1'b1}};
        vecs[1].e = '{{512{1'b1}}, {512{1'b1}}, 512'd1};
        vecs[1].stall = 3'b010;
        vecs[2].w = '{{512{1'b1}}, 512'd0, 512'hdead, 512'hbeef};
        vecs[2].a = 1025'd1 << 1024;
        vecs[2].e = '{512'd0, 512'd0, 512'd1};
        vecs[2].stall = 3'b101;
        vecs[3].w = '{512'd7, 512'd8, 512'd9, 512'd10};
        vecs[3].a = (1025'habcd << 512) | 1025'h1234;
        vecs[3].e = '{512'h1234, 512'habcd, 512'd0};
        vecs[3].stall = 3'b000;

        #2;
        chk_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Back-to-back jobs from the table.
        for (int v = 0; v < 4; v++) begin
            load_and_start(vecs[v].w);
            finish_job(DLY, vecs[v].a, vecs[v].e, vecs[v].stall);
        end

        // Reset after the second word, then a full reload from address 0.
        w = vecs[3].w;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = w[i];
            step();
        end
        chk("pre_rst_wr_en2", wr_en2, 1);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        rst = 1'b0;
        step();
        load_and_start(vecs[0].w);
        finish_job(3, vecs[0].a, vecs[0].e, 3'b000);

        // stop already high through start: needs a fresh rising edge.
        stop = 1'b1; ans = 1025'd99;
        step();
        load_and_start(vecs[1].w);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("held_stop_no_out", out_valid, 0);
            chk("held_stop_busy", busy, 1);
            chk("held_stop_err", err, 0);
        end
        stop = 1'b0;
        step(); step();
        chk("held_stop_still_wait", out_valid, 0);
        finish_job(0, vecs[0].a, vecs[0].e, 3'b000);

`ifdef MON_EXP_LOADER_TIMEOUT_EN
        load_and_start(vecs[2].w);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("tmo_err_early", err, 0);
            chk("tmo_no_out", out_valid, 0);
        end
        step();
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_out_end", out_valid, 0);
        step();
        chk("tmo_err_pulse", err, 0);
        chk("tmo_ready", in_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
